// File: rtl/mc_sequencer_pkg.sv
// Shared constants for the multi-cycle RV32I sequencer: opcodes,
// access-size codes, halt causes, FSM states and an opcode legality helper.
package mc_sequencer_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [1:0] WHB_BYTE = 2'b00;
    localparam logic [1:0] WHB_HALF = 2'b01;
    localparam logic [1:0] WHB_WORD = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b01;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, HALT
    } state_t;

    function automatic logic legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) ||
               (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Instruction and data memory request/ready bus of the sequencer.
// master: sequencer side (drives req/addr/we/be); slave: memory side.
interface mc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic            dmem_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rdata,
        output dmem_req, dmem_we, dmem_addr, dmem_be,
        input  dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rdata,
        input  dmem_req, dmem_we, dmem_addr, dmem_be,
        output dmem_ready
    );
endinterface

// File: rtl/mc_sequencer_lsu_lane_gen.sv
// Byte-lane generator: whb (size) + addr[1:0] -> be, misaligned, bad_size.
// Purely combinational; whb=11 is reported as bad_size with no lanes.
module lsu_lane_gen
    import mc_sequencer_pkg::*;
(
    input  logic [1:0] whb,
    input  logic [1:0] addr,
    output logic [3:0] be,
    output logic       misaligned,
    output logic       bad_size
);
    always_comb begin
        be         = 4'b0000;
        misaligned = 1'b0;
        bad_size   = 1'b0;
        unique case (whb)
            WHB_WORD: begin
                be         = 4'b1111;
                misaligned = (addr != 2'b00);
            end
            WHB_HALF: begin
                be         = 4'b0011 << addr;
                misaligned = addr[0];
            end
            WHB_BYTE: be = 4'b0001 << addr;
            default:  bad_size = 1'b1;
        endcase
    end
endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB FSM owning PC, IR,
// retire counter, memory handshakes (bus), rf_we gating, and halt logic.
module mc_sequencer
    import mc_sequencer_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    mc_sequencer_if.master    bus,
    output logic [31:0]       instr,
    input  logic              reg_write_i,
    input  logic [1:0]        whb_i,
    input  logic [XLEN-1:0]   alu_result,
    output logic              rf_we,
    output logic [XLEN-1:0]   pc,
    output logic [31:0]       instret,
    output logic              halted,
    output logic [1:0]        halt_cause
);
    // Last wait cycle index: the request is high for MEM_TIMEOUT cycles.
    localparam logic [7:0] TLIM = 8'(MEM_TIMEOUT - 1);

    state_t          state;
    logic [7:0]      tcnt;
    logic            imem_req_q;
    logic            dmem_req_q;
    logic            dmem_we_q;
    logic [XLEN-1:0] dmem_addr_q;
    logic [3:0]      dmem_be_q;

    logic [3:0]      lane_be;
    logic            misaligned;
    logic            bad_size;
    logic            is_mem;
    logic            is_store;
    logic            halt_now;
    logic [1:0]      halt_code;

    assign bus.imem_req  = imem_req_q;
    assign bus.imem_addr = pc;
    assign bus.dmem_req  = dmem_req_q;
    assign bus.dmem_we   = dmem_we_q;
    assign bus.dmem_addr = dmem_addr_q;
    assign bus.dmem_be   = dmem_be_q;

    assign is_store = (instr[6:0] == OP_STORE);
    assign is_mem   = (instr[6:0] == OP_LOAD) || is_store;

    lsu_lane_gen u_lane (
        .whb        (whb_i),
        .addr       (alu_result[1:0]),
        .be         (lane_be),
        .misaligned (misaligned),
        .bad_size   (bad_size)
    );

    // Access checks happen at the EXEC->MEM edge so a bad access
    // never raises dmem_req; a ready in the limit cycle beats timeout.
    always_comb begin
        halt_now  = 1'b0;
        halt_code = CAUSE_NONE;
        unique case (state)
            FETCH: if (imem_req_q && !bus.imem_ready && tcnt == TLIM) begin
                halt_now  = 1'b1;
                halt_code = CAUSE_TIMEOUT;
            end
            DECODE: if (!legal_op(instr[6:0])) begin
                halt_now  = 1'b1;
                halt_code = CAUSE_ILLEGAL;
            end
            EXEC: if (is_mem && bad_size) begin
                halt_now  = 1'b1;
                halt_code = CAUSE_ILLEGAL;
            end else if (is_mem && misaligned) begin
                halt_now  = 1'b1;
                halt_code = CAUSE_MISALIGN;
            end
            MEM: if (dmem_req_q && !bus.dmem_ready && tcnt == TLIM) begin
                halt_now  = 1'b1;
                halt_code = CAUSE_TIMEOUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            instret     <= '0;
            tcnt        <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
            dmem_be_q   <= '0;
            rf_we       <= 1'b0;
            halted      <= 1'b0;
            halt_cause  <= CAUSE_NONE;
        end else if (halt_now) begin
            state      <= HALT;
            halted     <= 1'b1;
            halt_cause <= halt_code;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            dmem_be_q  <= '0;
            rf_we      <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    // Only true in the first cycle after reset.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                        tcnt       <= '0;
                    end else if (bus.imem_ready) begin
                        instr      <= bus.imem_rdata;
                        imem_req_q <= 1'b0;
                        state      <= DECODE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                DECODE: state <= EXEC;
                EXEC: begin
                    if (is_mem) begin
                        dmem_req_q  <= 1'b1;
                        dmem_we_q   <= is_store;
                        dmem_addr_q <= {alu_result[XLEN-1:2], 2'b00};
                        dmem_be_q   <= lane_be;
                        tcnt        <= '0;
                        state       <= MEM;
                    end else begin
                        rf_we <= reg_write_i;
                        state <= WB;
                    end
                end
                MEM: begin
                    if (bus.dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        dmem_be_q  <= '0;
                        rf_we      <= reg_write_i & ~is_store;
                        state      <= WB;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                WB: begin
                    rf_we      <= 1'b0;
                    pc         <= pc + XLEN'(4);
                    instret    <= instret + 32'd1;
                    imem_req_q <= 1'b1;
                    tcnt       <= '0;
                    state      <= FETCH;
                end
                default: ;
            endcase
        end
    end
endmodule
